multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle decoder. A state-machine sequencer that drives the datapath one instruction phase at a time: IF, ID, EXE, MEM, WB. Supports stall-capable instruction/data memory handshakes, a memory timeout, and a retired-instruction counter. Sits between the instruction register and the datapath; it decodes the same ISA subset and uses the same aluOp/btype encodings.

---
 rtl/multicycle_control_unit.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: steps the datapath through IF/ID/EXE/MEM/WB with
// stall-capable memory handshakes, a wait timeout and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         fun,
  input  logic               br_cond,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               IRWr,
  output logic               PCWr,
  output logic               Jump,
  output logic               PCBr,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [1:0]         btype,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic               RegSrc,
  output logic               R_data_Src,
  output logic               MemWr,
  output logic               RegWr,
  output logic [2:0]         state,
  output logic               halted,
  output logic               bus_err,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_cnt
);
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [2:0]         r_state, w_next;
  logic [WW-1:0]      r_wait;
  logic               r_bus_err;
  logic [CNT_W-1:0]   r_cnt;

  logic w_rtype, w_lw, w_sw, w_br, w_j, w_halt, w_funok, w_bad;
  logic w_waiting, w_rdy, w_to, w_retire;
  logic [ALUOP_W-1:0] w_alu;
  logic [1:0]         w_bt;
  logic               w_sa, w_sb, w_ext, w_rs, w_rds;

  // Instruction decode; w_bad covers unknown opcodes and unknown R-type functs.
  always_comb begin
    w_rtype = (op == 6'b000000);
    w_lw    = (op == 6'b100011);
    w_sw    = (op == 6'b101011);
    w_br    = (op == 6'b000100) || (op == 6'b000101) || (op == 6'b000001);
    w_j     = (op == 6'b000010);
    w_halt  = (op == 6'b111111);
    w_funok = (fun == 6'b100000) || (fun == 6'b100010) || (fun == 6'b100100) ||
              (fun == 6'b100101) || (fun == 6'b000000);
    w_alu = '0; w_bt = 2'd0; w_sa = 1'b0; w_sb = 1'b0;
    w_ext = 1'b0; w_rs = 1'b0; w_rds = 1'b0; w_bad = 1'b0;
    case (op)
      6'b000000: begin
        w_sa = (fun == 6'b000000);
        case (fun)
          6'b100010: w_alu = ALUOP_W'(1);
          6'b100100: w_alu = ALUOP_W'(2);
          6'b100101: w_alu = ALUOP_W'(3);
          6'b000000: w_alu = ALUOP_W'(4);
          default:   w_alu = ALUOP_W'(0);
        endcase
        w_bad = !w_funok;
      end
      6'b001001: begin w_ext = 1'b1; w_rs = 1'b1; w_sb = 1'b1; end
      6'b001100: begin w_alu = ALUOP_W'(2); w_rs = 1'b1; w_sb = 1'b1; end
      6'b001101: begin w_alu = ALUOP_W'(3); w_rs = 1'b1; w_sb = 1'b1; end
      6'b001010: begin w_alu = ALUOP_W'(5); w_ext = 1'b1; w_rs = 1'b1; w_sb = 1'b1; end
      6'b100011: begin w_ext = 1'b1; w_sb = 1'b1; w_rs = 1'b1; w_rds = 1'b1; end
      6'b101011: begin w_ext = 1'b1; w_sb = 1'b1; end
      6'b000100: begin w_alu = ALUOP_W'(1); w_ext = 1'b1; w_bt = 2'd1; end
      6'b000101: begin w_alu = ALUOP_W'(1); w_ext = 1'b1; w_bt = 2'd2; end
      6'b000001: begin w_alu = ALUOP_W'(1); w_ext = 1'b1; w_bt = 2'd3; end
      6'b000010, 6'b111111: ;
      default:   w_bad = 1'b1;
    endcase
  end

  // Ready in the timeout cycle wins, so w_to requires the ready to be absent.
  always_comb begin
    w_waiting = (r_state == S_IF) || (r_state == S_MEM);
    w_rdy     = (r_state == S_IF) ? imem_ready : (r_state == S_MEM) ? dmem_ready : 1'b0;
    w_to      = (TIMEOUT != 0) && w_waiting && !w_rdy && (r_wait == TO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IF;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_waiting && !w_rdy && !w_to) ? r_wait + WW'(1) : '0;
      if (w_to)     r_bus_err <= 1'b1;
      if (w_retire) r_cnt     <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next   = S_IF;
    w_retire = 1'b0;
    case (r_state)
      S_IF:   w_next = w_to ? S_HALT : (imem_ready ? S_ID : S_IF);
      S_ID: begin
        if (w_halt)                  begin w_next = S_HALT; w_retire = 1'b1; end
        else if (w_j || w_bad)       begin w_next = S_IF;   w_retire = 1'b1; end
        else                         w_next = S_EXE;
      end
      S_EXE: begin
        if (w_br)             begin w_next = S_IF; w_retire = 1'b1; end
        else if (w_lw || w_sw) w_next = S_MEM;
        else                   w_next = S_WB;
      end
      S_MEM: begin
        if (w_to)            w_next = S_HALT;
        else if (dmem_ready) begin
          w_next   = w_sw ? S_IF : S_WB;
          w_retire = w_sw;
        end else             w_next = S_MEM;
      end
      S_WB:   begin w_next = S_IF; w_retire = 1'b1; end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  always_comb begin
    imem_req = 1'b0; dmem_req = 1'b0; IRWr = 1'b0; PCWr = 1'b0;
    Jump = 1'b0; PCBr = 1'b0; MemWr = 1'b0; RegWr = 1'b0;
    illegal = 1'b0; halted = 1'b0;
    aluOp = '0; btype = 2'd0; ALUSrcA = 1'b0; ALUSrcB = 1'b0;
    ExtSel = 1'b0; RegSrc = 1'b0; R_data_Src = 1'b0;
    if (r_state inside {S_ID, S_EXE, S_MEM, S_WB}) begin
      aluOp = w_alu; btype = w_bt; ALUSrcA = w_sa; ALUSrcB = w_sb;
      ExtSel = w_ext; RegSrc = w_rs; R_data_Src = w_rds;
    end
    case (r_state)
      S_IF:  begin imem_req = !w_to; IRWr = imem_ready; PCWr = imem_ready; end
      S_ID:  begin PCWr = w_j; Jump = w_j; illegal = w_bad; end
      S_EXE: begin PCWr = w_br && br_cond; PCBr = w_br && br_cond; end
      S_MEM: begin dmem_req = !w_to; MemWr = w_sw && !w_to; end
      S_WB:  RegWr = 1'b1;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
    // Nothing may strobe the datapath or memories while reset is held.
    if (!rst_n) begin
      imem_req = 1'b0; dmem_req = 1'b0; IRWr = 1'b0; PCWr = 1'b0;
      Jump = 1'b0; PCBr = 1'b0; MemWr = 1'b0; RegWr = 1'b0; illegal = 1'b0;
    end
  end

  assign state     = r_state;
  assign bus_err   = r_bus_err;
  assign instr_cnt = r_cnt;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control_unit;
  logic clk, rst_n, br_cond, imem_ready, dmem_ready;
  logic [5:0] op, fun;
  logic imem_req, dmem_req, IRWr, PCWr, Jump, PCBr, MemWr, RegWr;
  logic ALUSrcA, ALUSrcB, ExtSel, RegSrc, R_data_Src, halted, bus_err, illegal;
  logic [2:0] aluOp, state;
  logic [1:0] btype;
  logic [31:0] instr_cnt;

  multicycle_control_unit #(.ALUOP_W(3), .CNT_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .fun(fun), .br_cond(br_cond),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .IRWr(IRWr), .PCWr(PCWr), .Jump(Jump), .PCBr(PCBr),
    .aluOp(aluOp), .btype(btype), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .RegSrc(RegSrc), .R_data_Src(R_data_Src), .MemWr(MemWr),
    .RegWr(RegWr), .state(state), .halted(halted), .bus_err(bus_err),
    .illegal(illegal), .instr_cnt(instr_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe vector: {imem_req,dmem_req,IRWr,PCWr,Jump,PCBr,MemWr,RegWr,illegal,halted,bus_err}
  localparam logic [10:0] NONE = 11'h000, IREQ = 11'h400, DREQ = 11'h200, IRW = 11'h100,
                          PCW = 11'h080, JMP = 11'h040, PCB = 11'h020, RWR = 11'h008,
                          ILL = 11'h004, HLT = 11'h002, BER = 11'h001;
  localparam logic [10:0] FETCH = IREQ | IRW | PCW;
  // select vector: {aluOp[2:0],btype[1:0],ALUSrcA,ALUSrcB,ExtSel,RegSrc,R_data_Src}
  localparam logic [9:0] SEL0 = 10'b000_00_00000, SEL_ADD = 10'b000_00_00000,
                         SEL_LW = 10'b000_00_01111, SEL_BEQ = 10'b001_01_00100,
                         SEL_BNE = 10'b001_10_00100;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_J = 6'b000010, OP_HALT = 6'b111111,
                         F_ADD = 6'b100000, F_SLT = 6'b101010;

  typedef struct {
    logic [2:0]  st;
    logic [10:0] sb;
    logic [9:0]  sl;
    logic [31:0] cn;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  logic [10:0] act_sb;
  logic [9:0]  act_sl;

  assign act_sb = {imem_req, dmem_req, IRWr, PCWr, Jump, PCBr, MemWr, RegWr, illegal, halted, bus_err};
  assign act_sl = {aluOp, btype, ALUSrcA, ALUSrcB, ExtSel, RegSrc, R_data_Src};

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(e.tag, "state",   {29'd0, state}, {29'd0, e.st});
      chk(e.tag, "strobes", {21'd0, act_sb}, {21'd0, e.sb});
      chk(e.tag, "selects", {22'd0, act_sl}, {22'd0, e.sl});
      chk(e.tag, "instr_cnt", instr_cnt, e.cn);
    end
  end

  task automatic step(input logic [2:0] st, input logic [10:0] sb, input logic [9:0] sl,
                      input logic [31:0] cn, input string tag);
    exp_t x;
    x.st = st; x.sb = sb; x.sl = sl; x.cn = cn; x.tag = tag;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0; br_cond = 1'b0;
    op = OP_R; fun = F_ADD;
    @(posedge clk); #1;
    step(3'd0, NONE, SEL0, 0, "reset");
    step(3'd0, NONE, SEL0, 0, "reset");
    rst_n = 1'b1;
    // add: IF, ID, EXE, WB
    step(3'd0, FETCH, SEL0, 0, "add_if");
    step(3'd1, NONE, SEL_ADD, 0, "add_id");
    step(3'd2, NONE, SEL_ADD, 0, "add_exe");
    step(3'd4, RWR, SEL_ADD, 0, "add_wb");
    // lw with data memory ready after 3 wait cycles
    op = OP_LW;
    step(3'd0, FETCH, SEL0, 1, "lw_if");
    step(3'd1, NONE, SEL_LW, 1, "lw_id");
    step(3'd2, NONE, SEL_LW, 1, "lw_exe");
    repeat (3) step(3'd3, DREQ, SEL_LW, 1, "lw_mem_wait");
    dmem_ready = 1'b1;
    step(3'd3, DREQ, SEL_LW, 1, "lw_mem_rdy");
    dmem_ready = 1'b0;
    step(3'd4, RWR, SEL_LW, 1, "lw_wb");
    // beq taken, bne not taken
    op = OP_BEQ; br_cond = 1'b1;
    step(3'd0, FETCH, SEL0, 2, "beq_if");
    step(3'd1, NONE, SEL_BEQ, 2, "beq_id");
    step(3'd2, PCW | PCB, SEL_BEQ, 2, "beq_exe");
    op = OP_BNE; br_cond = 1'b0;
    step(3'd0, FETCH, SEL0, 3, "bne_if");
    step(3'd1, NONE, SEL_BNE, 3, "bne_id");
    step(3'd2, NONE, SEL_BNE, 3, "bne_exe");
    // illegal funct, then jump
    op = OP_R; fun = F_SLT;
    step(3'd0, FETCH, SEL0, 4, "slt_if");
    step(3'd1, ILL, SEL0, 4, "slt_id");
    op = OP_J;
    step(3'd0, FETCH, SEL0, 5, "j_if");
    step(3'd1, PCW | JMP, SEL0, 5, "j_id");
    // fetch ready arrives in the 15th wait cycle: no error
    op = OP_R; fun = F_ADD; imem_ready = 1'b0;
    repeat (14) step(3'd0, IREQ, SEL0, 6, "if_wait");
    imem_ready = 1'b1;
    step(3'd0, FETCH, SEL0, 6, "if_rdy15");
    step(3'd1, NONE, SEL_ADD, 6, "late_id");
    step(3'd2, NONE, SEL_ADD, 6, "late_exe");
    step(3'd4, RWR, SEL_ADD, 6, "late_wb");
    // fetch never ready: timeout to HALT with sticky bus_err
    imem_ready = 1'b0;
    repeat (14) step(3'd0, IREQ, SEL0, 7, "to_wait");
    step(3'd0, NONE, SEL0, 7, "to_cycle");
    imem_ready = 1'b1;
    repeat (3) step(3'd5, HLT | BER, SEL0, 7, "to_halt");
    rst_n = 1'b0;
    step(3'd0, NONE, SEL0, 0, "rst_after_to");
    rst_n = 1'b1;
    // halt instruction: absorbing for 20 cycles, then async reset
    op = OP_HALT;
    step(3'd0, FETCH, SEL0, 0, "halt_if");
    step(3'd1, NONE, SEL0, 0, "halt_id");
    for (int i = 0; i < 20; i++) begin
      imem_ready = i[0];
      dmem_ready = ~i[0];
      step(3'd5, HLT, SEL0, 1, "halt_hold");
    end
    imem_ready = 1'b1;
    rst_n = 1'b0;
    step(3'd0, NONE, SEL0, 0, "rst_in_halt");
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
